// File: rtl/exibidor_pkg.sv
// Shared state codes for the sequence player and the debug 7-segment path.
package exibidor_pkg;

  localparam logic [3:0] COD_INICIAL    = 4'h0;
  localparam logic [3:0] COD_PREPARACAO = 4'h1;
  localparam logic [3:0] COD_BUSCA      = 4'h2;
  localparam logic [3:0] COD_MOSTRA     = 4'h3;
  localparam logic [3:0] COD_INTERVALO  = 4'h4;
  localparam logic [3:0] COD_FIM        = 4'hF;

  typedef enum logic [3:0] {
    st_inicial    = COD_INICIAL,
    st_preparacao = COD_PREPARACAO,
    st_busca      = COD_BUSCA,
    st_mostra     = COD_MOSTRA,
    st_intervalo  = COD_INTERVALO,
    st_fim        = COD_FIM
  } estado_t;

  function automatic int maximo(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/exibidor_sequencia_contador.sv
// Modulo-M counter; M-1 comes in at run time so one instance serves both phases.
module contador_tempo #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] modulo_m1,
  output logic [W-1:0] valor,
  output logic         fim
);

  assign fim = (valor == modulo_m1);

  always_ff @(posedge clock) begin
    if (!reset || zera)
      valor <= '0;
    else if (conta)
      valor <= fim ? '0 : valor + 1'b1;
  end

endmodule

// File: rtl/exibidor_sequencia.sv
// Plays memory positions 0..limite on the LEDs with fixed on-time and dark gap.
// Optional EXIBIDOR_PAUSA_EN adds a pausar input that freezes playback.
module exibidor_sequencia
  import exibidor_pkg::*;
#(
  parameter int TEMPO_ACESO   = 50_000_000,
  parameter int TEMPO_APAGADO = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] mem_dado,
`ifdef EXIBIDOR_PAUSA_EN
  input  logic       pausar,
`endif
  output logic [3:0] mem_endereco,
  output logic [3:0] leds,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int TW = $clog2(maximo(TEMPO_ACESO, TEMPO_APAGADO)) + 1;
  localparam logic [TW-1:0] ACESO_M1   = TW'(TEMPO_ACESO - 1);
  localparam logic [TW-1:0] APAGADO_M1 = TW'(TEMPO_APAGADO - 1);

  estado_t       estado, prox;
  logic [3:0]    limite_reg;
  logic [TW-1:0] timer;
  logic          timer_fim;
  logic          pausa_ativa;
  logic          temporizando;

  assign temporizando = (estado == st_mostra) || (estado == st_intervalo);

`ifdef EXIBIDOR_PAUSA_EN
  assign pausa_ativa = pausar && temporizando;
`else
  assign pausa_ativa = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset)
      estado <= st_inicial;
    else
      estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      st_inicial:    if (iniciar) prox = st_preparacao;
      st_preparacao: prox = st_busca;
      st_busca:      prox = st_mostra;
      st_mostra:     if (!pausa_ativa && timer_fim) prox = st_intervalo;
      st_intervalo:
        if (!pausa_ativa && timer_fim)
          prox = (mem_endereco == limite_reg) ? st_fim : st_busca;
      st_fim:        if (iniciar) prox = st_preparacao;
      default:       prox = st_inicial;
    endcase
  end

  // Every phase change restarts the shared timer from zero.
  contador_tempo #(.W(TW)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .zera      (prox != estado),
    .conta     (temporizando && !pausa_ativa),
    .modulo_m1 ((estado == st_intervalo) ? APAGADO_M1 : ACESO_M1),
    .valor     (timer),
    .fim       (timer_fim)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_endereco <= '0;
      leds         <= '0;
      limite_reg   <= '0;
    end else begin
      case (estado)
        st_preparacao: begin
          mem_endereco <= '0;
          limite_reg   <= limite;
        end
        st_busca:     leds <= mem_dado;
        st_mostra:    if (prox == st_intervalo) leds <= '0;
        st_intervalo: if (prox == st_busca) mem_endereco <= mem_endereco + 4'd1;
        default: ;
      endcase
    end
  end

  assign pronto    = (estado == st_fim);
  assign db_estado = estado;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Directed bench for exibidor_sequencia with TEMPO_ACESO=4, TEMPO_APAGADO=2.
module tb_exibidor_sequencia;

  localparam int A   = 4;
  localparam int G   = 2;
  localparam int PER = 1 + A + G;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] mem_dado;
  logic [3:0] mem_endereco;
  logic [3:0] leds;
  logic       pronto;
  logic [3:0] db_estado;
`ifdef EXIBIDOR_PAUSA_EN
  logic       pausar = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // Memory holds 1,2,4,8,1,2,...; read data follows the registered address.
  assign mem_dado = 4'd1 << mem_endereco[1:0];

  exibidor_sequencia #(.TEMPO_ACESO(A), .TEMPO_APAGADO(G)) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .limite       (limite),
    .mem_dado     (mem_dado),
`ifdef EXIBIDOR_PAUSA_EN
    .pausar       (pausar),
`endif
    .mem_endereco (mem_endereco),
    .leds         (leds),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs e edges after entering preparacao, for a run up to lim.
  task automatic expect_at(input int e, input int lim,
                           output logic [3:0] st, output logic [3:0] lv,
                           output logic [3:0] ad);
    int q, p, r;
    if (e == 0) begin
      st = 4'h1; lv = 4'h0; ad = 4'h0;
    end else if (e >= 1 + (lim + 1) * PER) begin
      st = 4'hF; lv = 4'h0; ad = 4'(lim);
    end else begin
      q = e - 1; p = q / PER; r = q % PER;
      ad = 4'(p);
      if (r == 0)      begin st = 4'h2; lv = 4'h0; end
      else if (r <= A) begin st = 4'h3; lv = 4'd1 << (p % 4); end
      else             begin st = 4'h4; lv = 4'h0; end
    end
  endtask

  // One playback. chg_at: edge after which limite is forced to 0.
  // pause_at/pause_len: pausar window in edges. abort_at: reset pulse point.
  task automatic play(input int lim, input int chg_at, input int pause_at,
                      input int pause_len, input int abort_at);
    int total, e, n;
    logic paused;
    logic [3:0] st, lv, ad;
    total = 1 + (lim + 1) * PER;
    limite  = 4'(lim);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("prep_state", 32'(db_estado), 32'h1);
    e = 0; n = 0;
    while (e < total && n < 200) begin
      paused = (pause_len > 0) && (n >= pause_at) && (n < pause_at + pause_len);
`ifdef EXIBIDOR_PAUSA_EN
      pausar = paused;
`endif
      tick();
      n++;
      if (!paused) e++;
      expect_at(e, lim, st, lv, ad);
      chk($sformatf("state_e%0d", e), 32'(db_estado), 32'(st));
      chk($sformatf("leds_e%0d", e),  32'(leds),      32'(lv));
      chk($sformatf("addr_e%0d", e),  32'(mem_endereco), 32'(ad));
      chk($sformatf("pronto_e%0d", e), 32'(pronto), 32'(e == total));
      if (e == chg_at) limite = 4'h0;
      if (e == abort_at) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_state", 32'(db_estado), 32'h0);
        chk("abort_leds",  32'(leds), 32'h0);
        chk("abort_addr",  32'(mem_endereco), 32'h0);
        chk("abort_pronto", 32'(pronto), 32'h0);
        return;
      end
    end
`ifdef EXIBIDOR_PAUSA_EN
    pausar = 1'b0;
`endif
    chk("play_bound", 32'(e), 32'(total));
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b1; limite = 4'h3;
    tick(); tick();
    chk("rst_state",  32'(db_estado), 32'h0);
    chk("rst_leds",   32'(leds), 32'h0);
    chk("rst_pronto", 32'(pronto), 32'h0);
    chk("rst_addr",   32'(mem_endereco), 32'h0);

    // idle in inicial without a start request
    reset = 1'b1; iniciar = 1'b0;
    tick(); tick();
    chk("idle_state", 32'(db_estado), 32'h0);

    play(3, -1, 0, 0, -1);           // 1,2,4,8 then fim after 29 edges
    tick();
    chk("fim_hold", 32'(db_estado), 32'hF);
    play(0, -1, 0, 0, -1);           // single value, fim after 8 edges
    play(0, -1, 0, 0, -1);           // restart straight from fim
    play(3, 9, 0, 0, -1);            // limite dropped during the 2nd value
    limite = 4'h3;
    play(3, -1, 0, 0, 17);           // reset during mostra of address 2
    tick();
    chk("post_abort_idle", 32'(db_estado), 32'h0);
    play(3, -1, 0, 0, -1);           // replay from address 0
    play(15, -1, 0, 0, -1);          // all 16 positions, no wrap
`ifdef EXIBIDOR_PAUSA_EN
    play(3, -1, 3, 10, -1);          // 10-cycle pause inside first mostra
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exibidor_sequencia.md
# exibidor_sequencia

Plays a stored sequence back to the player: reads positions 0..`limite` from the game's sequence memory and lights each value on `leds` for a fixed on-time, separated by a dark gap, then reports `pronto`. It sits next to the player-input path, drives the same LED bank and reads the same memory, so the player sees what must be repeated.

## Interface
Parameters:
- `TEMPO_ACESO`, default 50_000_000: cycles each value stays lit; must be ≥1.
- `TEMPO_APAGADO`, default 25_000_000: cycles of dark gap after each value; must be ≥1.

Ports:
- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `iniciar`  in  1  start request, level-sampled in `inicial` and `fim`.
- `limite`  in  4  last address to show; sampled at start.
- `mem_dado`  in  4  memory read data; valid 1 cycle after `mem_endereco` changes (registered ROM).
- `mem_endereco`  out  4  memory read address.
- `leds`  out  4  displayed value; 0 when dark.
- `pronto`  out  1  high while in `fim`.
- `db_estado`  out  4  state code.

## Operation
- State codes: `inicial`=0, `preparacao`=1, `busca`=2, `mostra`=3, `intervalo`=4, `fim`=F.
- `inicial`: `leds`=0, `pronto`=0. `iniciar`=1 → `preparacao`.
- `preparacao` (1 cycle): `mem_endereco`←0, timer←0, `limite` latched → `busca`.
- `busca` (1 cycle): wait for `mem_dado` → `mostra`. `leds` are loaded from `mem_dado` on this exit edge.
- `mostra`: `leds` hold the value for exactly `TEMPO_ACESO` cycles. On timer end, timer←0 → `intervalo`.
- `intervalo`: `leds`=0 for exactly `TEMPO_APAGADO` cycles. On timer end:
  - if `mem_endereco` == latched `limite` → `fim`;
  - otherwise `mem_endereco`+1 → `busca`.
- `fim`: `pronto`=1, `leds`=0, `mem_endereco` held. `iniciar`=1 → `preparacao`; otherwise stays in `fim`.
- `iniciar` is ignored in all other states.
- Changes to `limite` during playback have no effect.
- `limite`=0 shows only address 0. `limite`=F shows all 16 positions; no address wrap occurs.
- Timer: width is `$clog2(max(TEMPO_ACESO,TEMPO_APAGADO))+1`. It compares against parameter−1, so on-time and gap are exact.

## Timing
- Reset (`reset`=0 at an edge, from any state): state=`inicial`, `leds`=0, `pronto`=0, `mem_endereco`=0, timer=0, `db_estado`=0. Reset takes priority over every other input.
- If `iniciar` is sampled high at edge k, then:
  - `preparacao` after edge k;
  - `busca` after edge k+1;
  - `mostra` with `leds` valid after edge k+2.
- Per position: 1 + `TEMPO_ACESO` + `TEMPO_APAGADO` cycles.
- Total playback from `preparacao` entry to `fim` entry: 1 + (`limite`+1)·(1+`TEMPO_ACESO`+`TEMPO_APAGADO`) cycles.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- `EXIBIDOR_PAUSA_EN` defined:
  - adds input port `pausar` (1 bit);
  - while `pausar`=1 in `mostra` or `intervalo`, the timer, state and `leds` freeze;
  - on release, timing resumes from the frozen count;
  - `pausar` has no effect in other states;
  - reset overrides pause.
- `EXIBIDOR_PAUSA_EN` undefined: no `pausar` port, and timing is always free-running.

## Structure
- Package `exibidor_pkg` holds the state type and the code constants (0,1,2,3,4,F) shared with the debug 7-segment path.
- Sub-module `contador_tempo`: parameterised modulo-M counter with `zera`, `conta`, and a `fim` output (high on count M−1).
  - One instance is used for both phases, reloaded on each phase change.
  - M is selected by state.

## Test plan
Bench parameters: `TEMPO_ACESO`=4, `TEMPO_APAGADO`=2. Memory contents: 1,2,4,8,…

1. Reset held low with `iniciar`=1 → `db_estado`=0, `leds`=0, `pronto`=0, `mem_endereco`=0.
2. `limite`=3 and a 1-cycle `iniciar` → `leds` show 1,2,4,8, each for 4 cycles, with 2 dark cycles between. `pronto` rises exactly 29 cycles after `preparacao` entry.
3. `limite`=0 → one value of 1 for 4 cycles, then `fim` 8 cycles after `preparacao` entry. Then `iniciar`=1 in `fim` → the playback repeats.
4. `limite` changed from 3 to 0 during the second value → all four values are still shown.
5. `reset` pulsed low during `mostra` of address 2 → the next cycle is `inicial` with `leds`=0. A later start replays from address 0.
6. With `EXIBIDOR_PAUSA_EN`: `pausar`=1 for 10 cycles in the middle of `mostra` → that value stays lit for 14 cycles in total; the rest of the timing is unchanged.
